// File: rtl/rcp_pkg.sv
// Shared definitions for the reciprocal / rsqrt interpolation pipe:
// default widths, the point/slope entry struct and the segment tables.
// Build macro: RCP_RSQRT_EN enables the rsqrt half of the table.
package rcp_pkg;

    localparam int IN_W_DEF   = 10;
    localparam int FRAC_W_DEF = 4;
    localparam int SLP_W_DEF  = 8;
    localparam int OUT_W_DEF  = 16;
    localparam int TAG_W_DEF  = 4;

    // Entries per function: one per {sel, seg} combination.
    localparam int SEG_N = 2 ** (IN_W_DEF - FRAC_W_DEF);

`ifdef RCP_RSQRT_EN
    localparam bit RSQRT_EN = 1'b1;
`else
    localparam bit RSQRT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [SLP_W_DEF-1:0] slp;
        logic [OUT_W_DEF-1:0] pnt;
    } seg_ent_t;

    typedef logic [SEG_N-1:0][OUT_W_DEF-1:0] pnt_tbl_t;
    typedef logic [SEG_N-1:0][SLP_W_DEF-1:0] slp_tbl_t;

    function automatic pnt_tbl_t mk_pnt(int top, int step);
        pnt_tbl_t t;
        for (int i = 0; i < SEG_N; i++) begin
            t[i] = OUT_W_DEF'(top - i * step);
        end
        return t;
    endfunction

    function automatic slp_tbl_t mk_slp(int top, int step);
        slp_tbl_t t;
        for (int i = 0; i < SEG_N; i++) begin
            t[i] = SLP_W_DEF'(top - i * step);
        end
        return t;
    endfunction

    // Points stay above 255*15 so pnt - slp*frac can never wrap.
    localparam pnt_tbl_t RCP_PNT = mk_pnt(65535, 900);
    localparam slp_tbl_t RCP_SLP = mk_slp(255, 2);
    localparam pnt_tbl_t RSQ_PNT = mk_pnt(60000, 700);
    localparam slp_tbl_t RSQ_SLP = mk_slp(180, 1);

endpackage

// File: rtl/rcp_interp_pipe_table.sv
// rcp_seg_table: combinational segment lookup, idx in, {slope, point} out.
// Ports: idx (table index {op, sel, seg}), ent ({slp, pnt}). Macro: RCP_RSQRT_EN.
module rcp_seg_table
    import rcp_pkg::*;
#(
    parameter int IDX_W = IN_W_DEF - FRAC_W_DEF + 1
) (
    input  logic [IDX_W-1:0]               idx,
    output logic [SLP_W_DEF+OUT_W_DEF-1:0] ent
);

    localparam int SUB_W = IDX_W - 1;

    logic [SUB_W-1:0] sub;
    seg_ent_t         rcp_e;
    seg_ent_t         sel_e;

    assign sub = idx[SUB_W-1:0];

    always_comb begin
        rcp_e.slp = RCP_SLP[sub];
        rcp_e.pnt = RCP_PNT[sub];
    end

`ifdef RCP_RSQRT_EN
    always_comb begin
        sel_e = rcp_e;
        if (idx[IDX_W-1]) begin
            sel_e.slp = RSQ_SLP[sub];
            sel_e.pnt = RSQ_PNT[sub];
        end
    end
`else
    // Reciprocal-only build: the op bit is always 0 here.
    logic unused_op;
    assign unused_op = idx[IDX_W-1];
    assign sel_e     = rcp_e;
`endif

    assign ent = sel_e;

endmodule

// File: rtl/rcp_interp_pipe.sv
// rcp_interp_pipe: 3-stage reciprocal / rsqrt piecewise-linear interpolator.
// Ports: clk, reset (sync, high), in_valid/in_ready/in_a/in_op/in_tag,
// out_valid/out_ready/out_data/out_tag. Macro: RCP_RSQRT_EN honours in_op.
module rcp_interp_pipe
    import rcp_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int SLP_W  = SLP_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_a,
    input  logic             in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int IDX_W  = IN_W - FRAC_W + 1;
    localparam int SEG_W  = IN_W - FRAC_W - 1;
    localparam int PROD_W = SLP_W + FRAC_W;

    logic en;

    // S1: operand register
    logic              s1_valid;
    logic [IN_W-1:0]   s1_a;
    logic              s1_op;
    logic [TAG_W-1:0]  s1_tag;

    // S2: segment select / table read
    logic              sel;
    logic [FRAC_W-1:0] frac;
    logic [SEG_W-1:0]  seg;
    logic [IDX_W-1:0]  idx;
    seg_ent_t          ent;
    logic              s2_valid;
    logic [OUT_W-1:0]  s2_pnt;
    logic [SLP_W-1:0]  s2_slp;
    logic [FRAC_W-1:0] s2_frac;
    logic [TAG_W-1:0]  s2_tag;

    // S3: interpolate
    logic [PROD_W-1:0] prod;

    // Whole pipe moves in lockstep; it only stalls when S3 is stuck.
    assign en       = !out_valid | out_ready;
    assign in_ready = en;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_op    <= 1'b0;
            s1_tag   <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_a     <= in_a;
            s1_op    <= in_op & RSQRT_EN;
            s1_tag   <= in_tag;
        end
    end

    // Upper half of the range uses one fewer seg bit; a[0] moves
    // into the seg MSB so the index width stays constant.
    assign sel  = s1_a[IN_W-1];
    assign frac = sel ? s1_a[FRAC_W:1] : s1_a[FRAC_W-1:0];
    assign seg  = sel ? {s1_a[0], s1_a[IN_W-2:FRAC_W+1]}
                      : s1_a[IN_W-2:FRAC_W];
    assign idx  = {s1_op, sel, seg};

    rcp_seg_table #(
        .IDX_W (IDX_W)
    ) u_table (
        .idx (idx),
        .ent (ent)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_pnt   <= '0;
            s2_slp   <= '0;
            s2_frac  <= '0;
            s2_tag   <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_pnt   <= ent.pnt;
            s2_slp   <= ent.slp;
            s2_frac  <= frac;
            s2_tag   <= s1_tag;
        end
    end

    assign prod = PROD_W'(s2_slp) * PROD_W'(s2_frac);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
        end else if (en) begin
            out_valid <= s2_valid;
            out_data  <= s2_pnt - OUT_W'(prod);
            out_tag   <= s2_tag;
        end
    end

endmodule

// File: tb/tb_rcp_interp_pipe.sv
// Testbench for rcp_interp_pipe: directed steps plus a randomized sweep
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_rcp_interp_pipe;
    import rcp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_a;
    logic        in_op;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_tag;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  tag;
        int          pnt;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    rcp_interp_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    function automatic exp_t model(int a, int op, int tag);
        exp_t e;
        int sel, frac, seg, row, p, s;
        sel = a / 512;
        if (sel == 0) begin
            frac = a % 16;
            seg  = (a % 512) / 16;
        end else begin
            frac = (a / 2) % 16;
            seg  = (a % 2) * 16 + (a % 512) / 32;
        end
        row = sel * 32 + seg;
        if (op != 0 && RSQRT_EN) begin
            p = int'(RSQ_PNT[row]);
            s = int'(RSQ_SLP[row]);
        end else begin
            p = int'(RCP_PNT[row]);
            s = int'(RCP_SLP[row]);
        end
        e.data = 16'(p - s * frac);
        e.tag  = 4'(tag);
        e.pnt  = p;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] obs,
                         input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", name, obs, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            cyc();
            n++;
        end
        check("drain", q.size(), 0);
        cyc();
    endtask

    // Scoreboard: decide at negedge what the next rising edge transfers.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                tests++;
                assert (q.size() != 0) else begin
                    fails++;
                    $error("FAIL spurious: out tag %0h data %0h, expected none",
                           out_tag, out_data);
                end
                if (q.size() != 0) begin
                    e = q.pop_front();
                    tests++;
                    assert (out_data === e.data) else begin
                        fails++;
                        $error("FAIL data: got %0h expected %0h", out_data, e.data);
                    end
                    tests++;
                    assert (out_tag === e.tag) else begin
                        fails++;
                        $error("FAIL tag: got %0h expected %0h", out_tag, e.tag);
                    end
                    tests++;
                    assert (int'(out_data) <= e.pnt) else begin
                        fails++;
                        $error("FAIL nowrap: got %0h expected <= %0h", out_data, e.pnt);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(int'(in_a), int'(in_op), int'(in_tag)));
            end
        end
    end

    initial begin
        int   v37;
        int   guard;
        logic acc;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_op     = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_tag", out_tag, 0);
        check("rst_ready", in_ready, 1);

        // First operand: latency and table entry 0.
        in_a     = 10'h000;
        in_op    = 1'b0;
        in_tag   = 4'd3;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("lat1", out_valid, 0);
        cyc();
        check("lat2", out_valid, 0);
        cyc();
        check("lat3", out_valid, 1);
        check("a0_data", out_data, 32'hFFFF);
        check("a0_tag", out_tag, 3);
        cyc();
        check("a0_gone", out_valid, 0);

        // Upper segment: index 48, frac 7.
        v37      = int'(RCP_PNT[48]) - int'(RCP_SLP[48]) * 7;
        in_a     = 10'h20F;
        in_tag   = 4'd5;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        check("sel1_valid", out_valid, 1);
        check("sel1_data", out_data, 32'(16'(v37)));
        check("sel1_tag", out_tag, 5);
        drain();

        // Eight back-to-back operands.
        for (int i = 0; i < 8; i++) begin
            in_a     = 10'($urandom_range(0, 1023));
            in_op    = 1'($urandom_range(0, 1));
            in_tag   = 4'(i);
            in_valid = 1'b1;
            cyc();
            if (i >= 2) check("b2b_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        cyc();
        check("b2b_tail1", out_valid, 1);
        cyc();
        check("b2b_tail2", out_valid, 1);
        cyc();
        check("b2b_end", out_valid, 0);
        drain();

        // Fill the pipe, then stall output for five cycles.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_a     = 10'($urandom_range(0, 1023));
            in_op    = 1'($urandom_range(0, 1));
            in_tag   = 4'(8 + i);
            in_valid = 1'b1;
            cyc();
        end
        in_a   = 10'($urandom_range(0, 1023));
        in_tag = 4'd11;
        for (int k = 0; k < 5; k++) begin
            check("stall_ready", in_ready, 0);
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, 32'(q[0].data));
            check("stall_tag", out_tag, 8);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        drain();

        // Reset with two operands in flight.
        in_valid = 1'b1;
        in_a     = 10'($urandom_range(0, 1023));
        in_tag   = 4'd1;
        cyc();
        in_a     = 10'($urandom_range(0, 1023));
        in_tag   = 4'd2;
        cyc();
        in_valid = 1'b0;
        reset    = 1'b1;
        cyc();
        check("flush_valid", out_valid, 0);
        reset = 1'b0;
        check("flush_ready", in_ready, 1);
        for (int k = 0; k < 6; k++) begin
            cyc();
            check("flush_quiet", out_valid, 0);
        end

        // Full sweep with random bubbles and output back-pressure.
        for (int op = 0; op < 2; op++) begin
            for (int a = 0; a < 1024; a++) begin
                if ($urandom_range(0, 7) == 0) begin
                    in_valid  = 1'b0;
                    out_ready = ($urandom_range(0, 3) != 0);
                    cyc();
                end
                in_a     = 10'(a);
                in_op    = 1'(op);
                in_tag   = 4'($urandom);
                in_valid = 1'b1;
                guard    = 0;
                do begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    #1;
                    acc = in_ready;
                    cyc();
                    guard++;
                end while (!acc && guard < 50);
                check("accept", acc, 1);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
